// File: rtl/alu_operand_if.sv
// Operand-collection bus between an operand source and the ALU operand stage.
// The master drives loads and the downstream handshake; the slave presents the collected set.
interface alu_operand_if #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_OPS   = 5
);
  logic [NUM_OPS-1:0][BUS_WIDTH-1:0] ops;
  logic [NUM_OPS-1:0]                reg_en;
  logic                              f_add;
  logic [NUM_OPS-1:0]                need_mask;
  logic                              flush;
  logic                              in_ready;
  logic                              op_valid;
  logic                              op_ready;
  logic [NUM_OPS-1:0][BUS_WIDTH-1:0] op_regs;
  logic [NUM_OPS-1:0]                loaded;
  logic                              ovr;
  logic [15:0]                       set_count;

  modport master (
    output ops, reg_en, f_add, need_mask, flush, op_ready,
    input  in_ready, op_valid, op_regs, loaded, ovr, set_count
  );

  modport slave (
    input  ops, reg_en, f_add, need_mask, flush, op_ready,
    output in_ready, op_valid, op_regs, loaded, ovr, set_count
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Collects a set of operands into registers and hands the complete set to the ALU
// with a valid/ready handshake; counts consumed sets and flags overwrites.
module alu_operand_stage #(
  parameter int                 BUS_WIDTH = 8,
  parameter int                 NUM_OPS   = 5,
  parameter logic [NUM_OPS-1:0] ZERO_MASK = 5'b01010
) (
  input logic         clk,
  input logic         rst_n,
  alu_operand_if.slave bus
);
  // state   | meaning
  // COLLECT | gathering operands, op_valid=0, loads always accepted
  // FULL    | complete set presented, loads accepted only with op_ready
  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_e;

  state_e                            state_q, state_d;
  logic [NUM_OPS-1:0][BUS_WIDTH-1:0] op_regs_q, op_regs_d;
  logic [NUM_OPS-1:0]                loaded_q, loaded_d;
  logic                              ovr_q, ovr_d;
  logic [15:0]                       set_count_q, set_count_d;

  logic               in_ready;
  logic               fire;
  logic [NUM_OPS-1:0] acc;
  logic [NUM_OPS-1:0] merged;

  function automatic logic complete(input logic [NUM_OPS-1:0] have,
                                    input logic [NUM_OPS-1:0] need);
    return (need != '0) && ((have & need) == need);
  endfunction

  assign in_ready = (state_q == COLLECT) | bus.op_ready;
  assign acc      = bus.reg_en & {NUM_OPS{in_ready}};
  assign fire     = (state_q == FULL) & bus.op_ready;
  assign merged   = loaded_q | acc;

  always_comb begin
    state_d     = state_q;
    op_regs_d   = op_regs_q;
    loaded_d    = loaded_q;
    ovr_d       = 1'b0;
    set_count_d = set_count_q;

    if (bus.flush) begin
      // Abandon wins over everything, including a pending handshake.
      state_d  = COLLECT;
      loaded_d = '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (acc[i]) begin
          op_regs_d[i] = (bus.f_add && ZERO_MASK[i]) ? '0 : bus.ops[i];
        end
      end

      if (fire) begin
        if (set_count_q != 16'hFFFF) begin
          set_count_d = set_count_q + 16'd1;
        end
        // Loads landing with the fire seed the next collection.
        loaded_d = acc;
        state_d  = complete(acc, bus.need_mask) ? FULL : COLLECT;
      end else if (state_q == COLLECT) begin
        loaded_d = merged;
        ovr_d    = |(acc & loaded_q);
        state_d  = complete(merged, bus.need_mask) ? FULL : COLLECT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      op_regs_q   <= '0;
      loaded_q    <= '0;
      ovr_q       <= 1'b0;
      set_count_q <= '0;
    end else begin
      state_q     <= state_d;
      op_regs_q   <= op_regs_d;
      loaded_q    <= loaded_d;
      ovr_q       <= ovr_d;
      set_count_q <= set_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.op_valid  = (state_q == FULL);
  assign bus.op_regs   = op_regs_q;
  assign bus.loaded    = loaded_q;
  assign bus.ovr       = ovr_q;
  assign bus.set_count = set_count_q;
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter BUS_WIDTH, default 8, operand width in bits; SHALL be >= 1.
REQ-002 Parameter NUM_OPS, default 5, number of operand registers; SHALL be 2..16.
REQ-003 Parameter ZERO_MASK, default 5'b01010 (NUM_OPS bits), operands forced to zero when f_add set.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ops  in  NUM_OPS x BUS_WIDTH  operand data, index i feeds register i.
REQ-007 reg_en  in  NUM_OPS  per-operand load request.
REQ-008 f_add  in  1  add mode; applies ZERO_MASK to loads this cycle.
REQ-009 need_mask  in  NUM_OPS  operands required for a complete set; held stable by source during a collection.
REQ-010 flush  in  1  synchronous abandon of current collection.
REQ-011 in_ready  out  1  loads accepted this cycle.
REQ-012 op_valid  out  1  complete operand set presented.
REQ-013 op_ready  in  1  downstream ALU accepts presented set.
REQ-014 op_regs  out  NUM_OPS x BUS_WIDTH  registered operands.
REQ-015 loaded  out  NUM_OPS  per-operand loaded flags.
REQ-016 ovr  out  1  one-cycle pulse: an already-loaded operand was overwritten.
REQ-017 set_count  out  16  number of operand sets consumed, saturating.

Function
REQ-018 States SHALL be COLLECT (op_valid=0) and FULL (op_valid=1); op_valid is a registered state decode.
REQ-019 in_ready SHALL equal (state==COLLECT) | op_ready; combinational from op_ready only.
REQ-020 Load accepted for operand i when reg_en[i] & in_ready; acc[i] denotes this.
REQ-021 On acc[i]: op_regs[i] <= (f_add & ZERO_MASK[i]) ? 0 : ops[i]; loaded[i] set next cycle.
REQ-022 Zeroed loads SHALL count as loaded; reg_en[i] still required.
REQ-023 Operands with reg_en[i]=0 or not accepted SHALL hold value.
REQ-024 COLLECT->FULL when need_mask!=0 and ((loaded|acc) & need_mask)==need_mask; op_valid asserts the cycle after the completing load (latency 1).
REQ-025 need_mask==0 SHALL never leave COLLECT; loads still update registers.
REQ-026 Handshake fires when op_valid & op_ready; on fire set_count increments, saturating at 16'hFFFF.
REQ-027 On fire, loaded <= acc (same-cycle loads start the next collection); state <= FULL if acc completes need_mask on its own, else COLLECT.
REQ-028 In FULL without op_ready, in_ready=0: reg_en ignored, op_regs and loaded stable.
REQ-029 ovr pulses next cycle when acc[i] & loaded[i] & state==COLLECT for any i; value overwritten, loaded stays set.
REQ-030 Loads in the fire cycle SHALL NOT raise ovr.
REQ-031 flush has priority: loaded <= 0, state <= COLLECT, ovr <= 0, same-cycle loads discarded, op_regs retained, no fire counted even if op_ready=1.
REQ-032 Bits of loaded outside need_mask SHALL still be tracked and cleared on fire/flush.

Reset
REQ-033 rst_n low SHALL immediately force op_regs=0, loaded=0, state=COLLECT (op_valid=0), ovr=0, set_count=0.
REQ-034 in_ready SHALL be 1 during and after reset given op_ready don't-care.
REQ-035 First load accepted on the first rising clk edge after rst_n deasserts; reset mid-collection discards partial set.

Verification (BUS_WIDTH=8, NUM_OPS=5, ZERO_MASK=01010)
REQ-036 need_mask=11111, reg_en=11111, ops={5,4,3,2,1}, f_add=0 -> next cycle op_valid=1, op_regs={5,4,3,2,1}; op_ready=1 -> op_valid=0, set_count=1.
REQ-037 f_add=1, reg_en=11111, ops all 8'hFF -> op_regs[1]=op_regs[3]=0, others FF, op_valid=1 next cycle.
REQ-038 need_mask=00011: load op0 cycle 0, op1 cycle 2 -> op_valid=0 until cycle 3, then 1; reg_en=00001 while FULL, op_ready=0 -> op_regs[0] unchanged, in_ready=0.
REQ-039 FULL, op_ready=1 with reg_en=00011 same cycle -> fire counted, state stays FULL, op_regs hold new values, ovr=0.
REQ-040 COLLECT, load op0=7 then op0=9 -> ovr one-cycle pulse, op_regs[0]=9; then flush=1 with reg_en=00010 -> loaded=0, op_regs[1] unchanged.
REQ-041 rst_n low while loaded=00101 -> loaded=0, op_regs=0, op_valid=0 asynchronously; 65536 fires -> set_count=FFFF.
